// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS iterative multiply/divide unit.
package mips_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        RUN  = 2'b10,
        FIX  = 2'b11
    } md_state_t;

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
module mips_muldiv_step
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH:0]   acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shifted;
    logic [WIDTH+1:0] diff;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, quotient}.
    always_comb begin
        sum     = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted = {acc[2*WIDTH-1:0], 1'b0};
        diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, operand};
        if (is_div) begin
            if (!diff[WIDTH+1]) begin
                acc_next = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
            end else begin
                acc_next = shifted;
            end
        end else begin
            acc_next = {1'b0, sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic             busyE,
    output logic             doneE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t          state, state_next;
    md_op_t             op_q;
    logic [WIDTH-1:0]   a_q, b_q, operand_q;
    logic [2*WIDTH:0]   acc, acc_step;
    logic [CW-1:0]      count;
    logic               neg_lo, neg_hi, div_zero, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_div, is_signed, b_zero;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    assign b_zero    = (b_q == '0);
    assign abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Magnitude results become signed ones by conditional negation in FIX.
    assign prod_fix  = neg_lo ? -acc[2*WIDTH-1:0]     : acc[2*WIDTH-1:0];
    assign quo_fix   = neg_lo ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
    assign rem_fix   = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand_q),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (startE) state_next = PREP;
            PREP:    state_next = (is_div && b_zero) ? FIX : RUN;
            RUN:     if (count == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busyE = (state != IDLE);
        doneE = done_q;
        hiE   = hi_q;
        loE   = lo_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= MD_MULT;
            a_q       <= '0;
            b_q       <= '0;
            operand_q <= '0;
            acc       <= '0;
            count     <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div_zero  <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (startE) begin
                        op_q <= md_op_t'(opE);
                        a_q  <= srcaE;
                        b_q  <= srcbE;
                    end
                end
                PREP: begin
                    count    <= CW'(WIDTH);
                    div_zero <= is_div && b_zero;
                    neg_lo   <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_hi   <= is_signed && is_div && a_q[WIDTH-1];
                    if (is_div) begin
                        acc       <= {{(WIDTH+1){1'b0}}, abs_a};
                        operand_q <= abs_b;
                    end else begin
                        acc       <= {{(WIDTH+1){1'b0}}, abs_b};
                        operand_q <= abs_a;
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count - CW'(1);
                end
                FIX: begin
                    if (div_zero) begin
                        lo_q <= '1;
                        hi_q <= a_q;
                    end else if (is_div) begin
                        lo_q <= quo_fix;
                        hi_q <= rem_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomized and directed checks of mips_muldiv_unit against an arithmetic reference model.
module tb_mips_muldiv_unit;

    localparam int W = 32;
    localparam int LIMIT = 200;

    logic         clk = 1'b0;
    logic         reset;
    logic         startE;
    logic [1:0]   opE;
    logic [W-1:0] srcaE, srcbE;
    logic         busyE, doneE;
    logic [W-1:0] hiE, loE;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .startE (startE),
        .opE    (opE),
        .srcaE  (srcaE),
        .srcbE  (srcbE),
        .busyE  (busyE),
        .doneE  (doneE),
        .hiE    (hiE),
        .loE    (loE)
    );

    // Architectural result computed with 64-bit host arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = sa * sb; {hi, lo} = p; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
            2'b10: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output logic done_obs, output logic done_next,
                         output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        startE = 1'b1; opE = op; srcaE = a; srcbE = b;
        @(negedge clk);
        startE = 1'b0;
        cycles = 0;
        while (busyE === 1'b1 && cycles < LIMIT) begin
            cycles++;
            @(negedge clk);
        end
        done_obs = doneE;
        hi = hiE;
        lo = loE;
        @(negedge clk);
        done_next = doneE;
    endtask

    task automatic test_reset();
        reset = 1'b0; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
        repeat (3) @(negedge clk);
        vectors++; if (busyE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%b want=0", busyE); end
        vectors++; if (doneE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got=%b want=0", doneE); end
        vectors++; if (hiE !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_hi got=%h want=0", hiE); end
        vectors++; if (loE !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_lo got=%h want=0", loE); end
        reset = 1'b1;
    endtask

    task automatic test_directed();
        vec_t tbl[9];
        int cyc, want_cyc;
        logic d0, d1;
        logic [31:0] hi, lo;
        tbl[0] = '{2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        tbl[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4] = '{2'b11, 32'd100,        32'd7,         32'd2,         32'd14};
        tbl[5] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6] = '{2'b11, 32'h0000_1234,  32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
        tbl[7] = '{2'b10, 32'hFFFF_FF9C,  32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF};
        tbl[8] = '{2'b10, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc, d0, d1, hi, lo);
            want_cyc = (tbl[i].op[1] && tbl[i].b == 32'd0) ? 2 : W + 2;
            vectors++; if (cyc !== want_cyc) begin miscompares++; $display("[TB] FAIL dir%0d_busy_cycles got=%0d want=%0d", i, cyc, want_cyc); end
            vectors++; if (hi !== tbl[i].hi) begin miscompares++; $display("[TB] FAIL dir%0d_hi got=%h want=%h", i, hi, tbl[i].hi); end
            vectors++; if (lo !== tbl[i].lo) begin miscompares++; $display("[TB] FAIL dir%0d_lo got=%h want=%h", i, lo, tbl[i].lo); end
            vectors++; if (d0 !== 1'b1 || d1 !== 1'b0) begin miscompares++; $display("[TB] FAIL dir%0d_done_pulse got=%b%b want=10", i, d0, d1); end
        end
    endtask

    task automatic test_random();
        int cyc, want_cyc;
        logic d0, d1;
        logic [1:0] op;
        logic [31:0] a, b, hi, lo, ehi, elo;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            model(op, a, b, ehi, elo);
            do_op(op, a, b, cyc, d0, d1, hi, lo);
            want_cyc = (op[1] && b == 32'd0) ? 2 : W + 2;
            vectors++; if (cyc !== want_cyc) begin miscompares++; $display("[TB] FAIL rnd%0d_busy_cycles got=%0d want=%0d", i, cyc, want_cyc); end
            vectors++; if (hi !== ehi || lo !== elo) begin
                miscompares++;
                $display("[TB] FAIL rnd%0d_result op=%0d a=%h b=%h got=%h_%h want=%h_%h", i, op, a, b, hi, lo, ehi, elo);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [31:0] a2, b2, ehi, elo;
        @(negedge clk);
        startE = 1'b1; opE = 2'b00; srcaE = 32'd5; srcbE = 32'd6;
        @(negedge clk);
        startE = 1'b0;
        c = 0;
        while (busyE === 1'b1 && c < LIMIT) begin
            c++;
            if (c == 10) begin startE = 1'b1; opE = 2'b11; srcaE = 32'd9; srcbE = 32'd3; end
            else startE = 1'b0;
            @(negedge clk);
        end
        startE = 1'b0;
        vectors++; if (c !== W + 2) begin miscompares++; $display("[TB] FAIL busy_ignore_cycles got=%0d want=%0d", c, W + 2); end
        vectors++; if (hiE !== 32'd0 || loE !== 32'd30) begin miscompares++; $display("[TB] FAIL busy_ignore_result got=%h_%h want=00000000_0000001e", hiE, loE); end
        vectors++; if (doneE !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_ignore_done got=%b want=1", doneE); end
        // Issue the next operation in the doneE cycle itself.
        a2 = $urandom; b2 = $urandom;
        model(2'b01, a2, b2, ehi, elo);
        startE = 1'b1; opE = 2'b01; srcaE = a2; srcbE = b2;
        @(negedge clk);
        startE = 1'b0;
        vectors++; if (busyE !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept got=%b want=1", busyE); end
        c = 0;
        while (busyE === 1'b1 && c < LIMIT) begin c++; @(negedge clk); end
        vectors++; if (c !== W + 2) begin miscompares++; $display("[TB] FAIL b2b_cycles got=%0d want=%0d", c, W + 2); end
        vectors++; if (hiE !== ehi || loE !== elo) begin miscompares++; $display("[TB] FAIL b2b_result got=%h_%h want=%h_%h", hiE, loE, ehi, elo); end
    endtask

    task automatic test_reset_midop();
        int c, cyc;
        logic seen;
        logic d0, d1;
        logic [31:0] hi, lo;
        @(negedge clk);
        startE = 1'b1; opE = 2'b10; srcaE = 32'h1234_5678; srcbE = 32'h0000_0321;
        @(negedge clk);
        startE = 1'b0;
        // c counts busy cycles: 1 is PREP, 16 is the fifteenth RUN cycle.
        c = 1;
        while (c < 16 && busyE === 1'b1) begin c++; @(negedge clk); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (busyE !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy got=%b want=0", busyE); end
        vectors++; if (doneE !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_done got=%b want=0", doneE); end
        vectors++; if (hiE !== 32'd0 || loE !== 32'd0) begin miscompares++; $display("[TB] FAIL midreset_hilo got=%h_%h want=0_0", hiE, loE); end
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (doneE !== 1'b0 || busyE !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_ghost_done got=%b want=0", seen); end
        do_op(2'b11, 32'd100, 32'd7, cyc, d0, d1, hi, lo);
        vectors++; if (cyc !== W + 2 || hi !== 32'd2 || lo !== 32'd14) begin
            miscompares++;
            $display("[TB] FAIL midreset_next_op got=%0d/%h_%h want=%0d/00000002_0000000e", cyc, hi, lo, W + 2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
